// File: rtl/adder_sub_arbiter.sv
// adder_sub_arbiter
// Two-requester round-robin front end for a shared adder_sub datapath.
// One operation is in flight at a time. The flow is IDLE (grant/accept), then
// EXEC (drive adder_sub and wait for out_en), then RESP (one-cycle response
// pulse). The round-robin pointer flips after every served request.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   reqN_valid/ready               request handshake, N = 0,1 (ready is combinational)
//   reqN_a, reqN_b, reqN_op, reqN_cin  operands, op (0 = add, 1 = sub), carry-in
//   rspN_valid/data/carry/err      registered one-cycle response, zero when not valid
//   as_a, as_b, as_add_en, as_sub_en, as_carry_in  registered drive into adder_sub
//   as_data_out, as_carry_out, as_out_en           result returned by adder_sub
module adder_sub_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    input  logic             req1_cin,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_carry,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_carry,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_add_en,
    output logic             as_sub_en,
    output logic             as_carry_in,
    input  logic [WIDTH-1:0] as_data_out,
    input  logic             as_carry_out,
    input  logic             as_out_en
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               prio_r;
    logic               grant_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               grant_id_s;
    logic               accept_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic               sel_op_s;
    logic               sel_cin_s;
    logic               exec_last_s;

    logic [WIDTH-1:0]   as_a_r;
    logic [WIDTH-1:0]   as_b_r;
    logic               as_add_en_r;
    logic               as_sub_en_r;
    logic               as_carry_in_r;

    logic               rsp0_valid_r;
    logic [WIDTH-1:0]   rsp0_data_r;
    logic               rsp0_carry_r;
    logic               rsp0_err_r;
    logic               rsp1_valid_r;
    logic [WIDTH-1:0]   rsp1_data_r;
    logic               rsp1_carry_r;
    logic               rsp1_err_r;

    // Grant selection and payload mux; readys are suppressed while reset is asserted.
    always_comb begin
        grant_id_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id_s = prio_r;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end

        accept_s = (!reset) && (state_r == ST_IDLE) && (req0_valid || req1_valid);

        if (grant_id_s) begin
            sel_a_s   = req1_a;
            sel_b_s   = req1_b;
            sel_op_s  = req1_op;
            sel_cin_s = req1_cin;
        end else begin
            sel_a_s   = req0_a;
            sel_b_s   = req0_b;
            sel_op_s  = req0_op;
            sel_cin_s = req0_cin;
        end

        // EXEC ends on a datapath answer or on the last allowed wait cycle.
        exec_last_s = (state_r == ST_EXEC) && (as_out_en || (cnt_r == CNT_LAST));
    end

    assign req0_ready = accept_s & ~grant_id_s;
    assign req1_ready = accept_s &  grant_id_s;

    // Next-state decode for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (exec_last_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, datapath drive, wait counter, response capture and priority pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r        <= 1'b0;
            grant_r       <= 1'b0;
            cnt_r         <= '0;
            as_a_r        <= '0;
            as_b_r        <= '0;
            as_add_en_r   <= 1'b0;
            as_sub_en_r   <= 1'b0;
            as_carry_in_r <= 1'b0;
            rsp0_valid_r  <= 1'b0;
            rsp0_data_r   <= '0;
            rsp0_carry_r  <= 1'b0;
            rsp0_err_r    <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp1_data_r   <= '0;
            rsp1_carry_r  <= 1'b0;
            rsp1_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // The as_* registers double as the operand latch for the whole EXEC phase.
                        grant_r       <= grant_id_s;
                        cnt_r         <= '0;
                        as_a_r        <= sel_a_s;
                        as_b_r        <= sel_b_s;
                        as_carry_in_r <= sel_cin_s;
                        as_add_en_r   <= ~sel_op_s;
                        as_sub_en_r   <= sel_op_s;
                    end
                end
                ST_EXEC: begin
                    if (exec_last_s) begin
                        as_a_r        <= '0;
                        as_b_r        <= '0;
                        as_carry_in_r <= 1'b0;
                        as_add_en_r   <= 1'b0;
                        as_sub_en_r   <= 1'b0;
                        cnt_r         <= '0;
                        // A timeout forces data/carry to zero and flags err.
                        if (grant_r) begin
                            rsp1_valid_r <= 1'b1;
                            rsp1_data_r  <= as_out_en ? as_data_out : '0;
                            rsp1_carry_r <= as_out_en & as_carry_out;
                            rsp1_err_r   <= ~as_out_en;
                        end else begin
                            rsp0_valid_r <= 1'b1;
                            rsp0_data_r  <= as_out_en ? as_data_out : '0;
                            rsp0_carry_r <= as_out_en & as_carry_out;
                            rsp0_err_r   <= ~as_out_en;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    prio_r       <= ~grant_r;
                    rsp0_valid_r <= 1'b0;
                    rsp0_data_r  <= '0;
                    rsp0_carry_r <= 1'b0;
                    rsp0_err_r   <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    rsp1_data_r  <= '0;
                    rsp1_carry_r <= 1'b0;
                    rsp1_err_r   <= 1'b0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign as_a        = as_a_r;
    assign as_b        = as_b_r;
    assign as_add_en   = as_add_en_r;
    assign as_sub_en   = as_sub_en_r;
    assign as_carry_in = as_carry_in_r;

    assign rsp0_valid  = rsp0_valid_r;
    assign rsp0_data   = rsp0_data_r;
    assign rsp0_carry  = rsp0_carry_r;
    assign rsp0_err    = rsp0_err_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp1_data   = rsp1_data_r;
    assign rsp1_carry  = rsp1_carry_r;
    assign rsp1_err    = rsp1_err_r;

endmodule

// File: tb/tb_adder_sub_arbiter.sv
// Self-checking bench for adder_sub_arbiter with a behavioural adder_sub model.
module tb_adder_sub_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
    logic       req0_op = 1'b0, req0_cin = 1'b0, req1_op = 1'b0, req1_cin = 1'b0;
    logic       rsp0_valid, rsp0_carry, rsp0_err, rsp1_valid, rsp1_carry, rsp1_err;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] as_a, as_b, as_data_out;
    logic       as_add_en, as_sub_en, as_carry_in, as_carry_out, as_out_en;
    logic       stall = 1'b0;
    logic [8:0] model_sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol_cnt = 0;
    int add_cyc = 0;
    int sub_cyc = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       carry;
        logic       err;
        int         cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   exp_rd = 0;
    int   obs_rd = 0;

    adder_sub_arbiter #(.WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_cin(req1_cin),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_carry(rsp0_carry), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_carry(rsp1_carry), .rsp1_err(rsp1_err),
        .as_a(as_a), .as_b(as_b), .as_add_en(as_add_en), .as_sub_en(as_sub_en),
        .as_carry_in(as_carry_in), .as_data_out(as_data_out), .as_carry_out(as_carry_out),
        .as_out_en(as_out_en)
    );

    always #5 clk = ~clk;

    // adder_sub model: add = A+B+cin, sub = A+~B+1; answers immediately unless stalled.
    assign model_sum    = as_sub_en ? ({1'b0, as_a} + {1'b0, ~as_b} + 9'd1)
                                    : ({1'b0, as_a} + {1'b0, as_b} + {8'd0, as_carry_in});
    assign as_data_out  = model_sum[7:0];
    assign as_carry_out = model_sum[8];
    assign as_out_en    = (as_add_en | as_sub_en) & ~stall;

    function automatic rec_t mk_exp(input int id, input logic [7:0] a, input logic [7:0] b,
                                    input logic op, input logic cin, input logic stl, input int c);
        rec_t r;
        logic [8:0] s;
        if (op) s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else    s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        r.id = id;
        r.cyc = c;
        if (stl) begin
            r.data = 8'd0; r.carry = 1'b0; r.err = 1'b1;
        end else begin
            r.data = s[7:0]; r.carry = s[8]; r.err = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs accepts (with expected result) and responses, counts enable cycles and protocol violations.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready) exp_q.push_back(mk_exp(0, req0_a, req0_b, req0_op, req0_cin, stall, cyc));
            if (req1_valid && req1_ready) exp_q.push_back(mk_exp(1, req1_a, req1_b, req1_op, req1_cin, stall, cyc));
        end
        if (rsp0_valid === 1'b1) obs_q.push_back('{0, rsp0_data, rsp0_carry, rsp0_err, cyc});
        if (rsp1_valid === 1'b1) obs_q.push_back('{1, rsp1_data, rsp1_carry, rsp1_err, cyc});
        if (as_add_en === 1'b1) add_cyc <= add_cyc + 1;
        if (as_sub_en === 1'b1) sub_cyc <= sub_cyc + 1;
        if (cyc > 0) begin
            viol_cnt <= viol_cnt
                + int'(req0_ready === 1'b1 && req1_ready === 1'b1)
                + int'(req0_ready === 1'b1 && req0_valid !== 1'b1)
                + int'(req1_ready === 1'b1 && req1_valid !== 1'b1)
                + int'(rsp0_valid === 1'b1 && rsp1_valid === 1'b1)
                + int'(rsp0_valid !== 1'b1 && {rsp0_data, rsp0_carry, rsp0_err} !== 10'd0)
                + int'(rsp1_valid !== 1'b1 && {rsp1_data, rsp1_carry, rsp1_err} !== 10'd0)
                + int'(as_add_en === 1'b1 && as_sub_en === 1'b1)
                + int'(as_add_en !== 1'b1 && as_sub_en !== 1'b1 && {as_a, as_b, as_carry_in} !== 17'd0);
        end
    end

    task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic op, input logic cin, output bit ok);
        @(posedge clk); #1;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_cin = cin; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_cin = cin; req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(posedge clk); #1;
            if (obs_q.size() >= obs_rd + n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        rec_t e, o;
        req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd3; req1_b = 8'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready, as_a, as_b, as_add_en, as_sub_en, as_carry_in} !== 21'd0 ||
                {rsp0_valid, rsp0_data, rsp0_carry, rsp0_err, rsp1_valid, rsp1_data, rsp1_carry, rsp1_err} !== 20'd0)
                begin failures++; $display("FAIL reset_outputs cycle %0d: ready=%b%b add_en=%b sub_en=%b rsp_valid=%b%b, required all 0",
                                           i, req0_ready, req1_ready, as_add_en, as_sub_en, rsp0_valid, rsp1_valid); end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_first_grant: ready0/1=%b%b, required 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reset_first_rsp: no response, required one"); end
        else begin
            e = exp_q[exp_rd]; exp_rd++; o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o.id !== 0 || o.data !== 8'd3 || o.data !== e.data || o.err !== 1'b0) begin
                failures++; $display("FAIL reset_first_rsp_data: id=%0d data=%0d err=%b, required id=0 data=3 err=0", o.id, o.data, o.err);
            end
        end
    endtask

    task automatic test_add_req0();
        bit ok;
        rec_t e, o;
        int a0 = add_cyc;
        int s0 = sub_cyc;
        drive_req(0, 8'd200, 8'd100, 1'b0, 1'b0, ok);
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL add0_rsp: no response, required one"); end
        else begin
            e = exp_q[exp_rd]; exp_rd++; o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o.id !== 0 || o.data !== 8'd44 || o.carry !== 1'b1 || o.err !== 1'b0) begin
                failures++; $display("FAIL add0_result: id=%0d data=%0d carry=%b err=%b, required 0/44/1/0", o.id, o.data, o.carry, o.err);
            end
            checks++;
            if (o.cyc - e.cyc !== 2) begin
                failures++; $display("FAIL add0_latency: %0d cycles, required 2", o.cyc - e.cyc);
            end
        end
        checks++;
        if (add_cyc - a0 !== 1 || sub_cyc - s0 !== 0) begin
            failures++; $display("FAIL add0_enables: add_en cycles=%0d sub_en cycles=%0d, required 1/0", add_cyc - a0, sub_cyc - s0);
        end
    endtask

    task automatic test_req1_ops();
        bit ok;
        rec_t e, o;
        int s0 = sub_cyc;
        drive_req(1, 8'd50, 8'd20, 1'b1, 1'b0, ok);
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL sub1_rsp: no response, required one"); end
        else begin
            e = exp_q[exp_rd]; exp_rd++; o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o.id !== 1 || o.data !== 8'd30 || o.carry !== 1'b1 || o.err !== 1'b0 || o.data !== e.data) begin
                failures++; $display("FAIL sub1_result: id=%0d data=%0d carry=%b err=%b, required 1/30/1/0", o.id, o.data, o.carry, o.err);
            end
        end
        checks++;
        if (sub_cyc - s0 !== 1) begin
            failures++; $display("FAIL sub1_enable: sub_en cycles=%0d, required 1", sub_cyc - s0);
        end
        drive_req(1, 8'd255, 8'd0, 1'b0, 1'b1, ok);
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL add1_rsp: no response, required one"); end
        else begin
            e = exp_q[exp_rd]; exp_rd++; o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o.id !== 1 || o.data !== 8'd0 || o.carry !== 1'b1 || o.err !== 1'b0) begin
                failures++; $display("FAIL add1_wrap: id=%0d data=%0d carry=%b err=%b, required 1/0/1/0", o.id, o.data, o.carry, o.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit g0, g1;
        int n_acc = 0;
        rec_t e, o;
        int prev_cyc = 0;
        @(posedge clk); #1;
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom); req0_cin = 1'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom); req1_cin = 1'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 60 && n_acc < 6; k++) begin
            @(negedge clk);
            g0 = req0_ready; g1 = req1_ready;
            @(posedge clk); #1;
            if (g0) begin req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom); req0_cin = 1'($urandom); end
            if (g1) begin req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom); req1_cin = 1'($urandom); end
            n_acc += int'(g0) + int'(g1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (n_acc !== 6) begin failures++; $display("FAIL b2b_accepts: %0d accepts, required 6", n_acc); end
        wait_rsp(6, 40, ok);
        checks++;
        if (!ok || exp_q.size() < exp_rd + 6) begin
            failures++; $display("FAIL b2b_rsp_count: %0d responses, required 6", obs_q.size() - obs_rd);
        end else begin
            for (int i = 0; i < 6; i++) begin
                e = exp_q[exp_rd + i]; o = obs_q[obs_rd + i];
                checks++;
                if (e.id !== i % 2) begin
                    failures++; $display("FAIL b2b_grant_order op %0d: granted %0d, required %0d", i, e.id, i % 2);
                end
                checks++;
                if (o.id !== e.id || o.data !== e.data || o.carry !== e.carry || o.err !== e.err || o.cyc - e.cyc !== 2) begin
                    failures++; $display("FAIL b2b_result op %0d: id=%0d data=%0d carry=%b err=%b lat=%0d, required id=%0d data=%0d carry=%b err=0 lat=2",
                                         i, o.id, o.data, o.carry, o.err, o.cyc - e.cyc, e.id, e.data, e.carry);
                end
                if (i > 0) begin
                    checks++;
                    if (e.cyc - prev_cyc !== 3) begin
                        failures++; $display("FAIL b2b_spacing op %0d: %0d cycles after previous accept, required 3", i, e.cyc - prev_cyc);
                    end
                end
                prev_cyc = e.cyc;
            end
            exp_rd += 6; obs_rd += 6;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        rec_t e, o;
        int a0 = add_cyc;
        stall = 1'b1;
        drive_req(0, 8'd10, 8'd20, 1'b0, 1'b0, ok);
        wait_rsp(1, 20, ok);
        stall = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL timeout_rsp: no response, required one"); end
        else begin
            e = exp_q[exp_rd]; exp_rd++; o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o.id !== 0 || o.err !== 1'b1 || o.data !== 8'd0 || o.carry !== 1'b0) begin
                failures++; $display("FAIL timeout_result: id=%0d data=%0d carry=%b err=%b, required 0/0/0/1", o.id, o.data, o.carry, o.err);
            end
            checks++;
            if (o.cyc - e.cyc !== 5) begin
                failures++; $display("FAIL timeout_latency: %0d cycles, required 5", o.cyc - e.cyc);
            end
        end
        checks++;
        if (add_cyc - a0 !== 4) begin
            failures++; $display("FAIL timeout_exec_len: add_en cycles=%0d, required 4", add_cyc - a0);
        end
        drive_req(1, 8'd1, 8'd2, 1'b0, 1'b0, ok);
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL post_timeout_rsp: no response, required one"); end
        else begin
            e = exp_q[exp_rd]; exp_rd++; o = obs_q[obs_rd]; obs_rd++;
            checks++;
            if (o.id !== 1 || o.data !== 8'd3 || o.carry !== 1'b0 || o.err !== 1'b0 || o.cyc - e.cyc !== 2) begin
                failures++; $display("FAIL post_timeout_result: id=%0d data=%0d carry=%b err=%b lat=%0d, required 1/3/0/0 lat=2",
                                     o.id, o.data, o.carry, o.err, o.cyc - e.cyc);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        rec_t o;
        stall = 1'b1;
        drive_req(1, 8'd9, 8'd3, 1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_accept: req1 not accepted, required accept"); end
        @(posedge clk); #1;
        reset = 1'b1;
        req0_a = 8'd5; req0_b = 8'd6; req0_op = 1'b0; req0_cin = 1'b0;
        req1_a = 8'd7; req1_b = 8'd8; req1_op = 1'b0; req1_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({as_add_en, as_sub_en, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 6'd0) begin
            failures++; $display("FAIL rstmid_outputs: add_en=%b sub_en=%b rsp_valid=%b%b ready=%b%b, required all 0",
                                 as_add_en, as_sub_en, rsp0_valid, rsp1_valid, req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd = exp_q.size();
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL rstmid_next_grant: ready0/1=%b%b, required 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (obs_q.size() !== obs_rd) begin
            failures++; $display("FAIL rstmid_no_rsp: %0d responses after reset, required 0", obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_post_rsp: no response, required one"); end
        else begin
            o = obs_q[obs_rd]; obs_rd++; exp_rd++;
            checks++;
            if (o.id !== 0 || o.data !== 8'd11 || o.carry !== 1'b0 || o.err !== 1'b0) begin
                failures++; $display("FAIL rstmid_post_result: id=%0d data=%0d carry=%b err=%b, required 0/11/0/0", o.id, o.data, o.carry, o.err);
            end
        end
    endtask

    task automatic test_invariants();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (viol_cnt !== 0) begin
            failures++; $display("FAIL protocol_invariants: %0d violations, required 0", viol_cnt);
        end
        checks++;
        if (obs_q.size() !== obs_rd) begin
            failures++; $display("FAIL stray_responses: %0d unexpected responses, required 0", obs_q.size() - obs_rd);
        end
    endtask

    initial begin
        test_reset();
        test_add_req0();
        test_req1_ops();
        test_back_to_back();
        test_timeout();
        test_reset_mid_exec();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_sub_arbiter.md
# adder_sub_arbiter

Two-requester round-robin controller that shares one `adder_sub` datapath. It accepts add/subtract requests through valid/ready handshakes and drives the `adder_sub` operand and enable ports for the granted requester. It captures `data_out`/`carry_out` when `out_en` is asserted and returns the result to the requester as a one-cycle response pulse. A bounded wait on `out_en` produces an error response if the datapath never answers.

## Interface
- `WIDTH`, 8, operand/result width (matches `adder_sub`)
- `TIMEOUT`, 4, max EXEC cycles waiting for `as_out_en` (≥1)

- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `reqN_valid`  in  1  request N (N=0,1) presents an operation
- `reqN_ready`  out  1  request N accepted this cycle (valid&ready)
- `reqN_a`, `reqN_b`  in  WIDTH  operands
- `reqN_op`  in  1  0 = add, 1 = subtract
- `reqN_cin`  in  1  carry-in
- `rspN_valid`  out  1  one-cycle response pulse for requester N
- `rspN_data`  out  WIDTH  captured `data_out`
- `rspN_carry`  out  1  captured `carry_out`
- `rspN_err`  out  1  1 = timeout, data/carry forced 0
- `as_a`, `as_b`  out  WIDTH  to `adder_sub` A, B
- `as_add_en`, `as_sub_en`, `as_carry_in`  out  1  to `adder_sub`
- `as_data_out`  in  WIDTH; `as_carry_out`, `as_out_en`  in  1  from `adder_sub` (combinational)

## Operation
- FSM: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Grant logic is combinational from `reqN_valid` and the priority pointer `prio` (0 or 1).
  - If only one requester is valid, grant it.
  - If both are valid, grant `prio`.
  - Assert `reqG_ready` for the granted side only. On that edge, latch a, b, op, cin, and grant id G, then go to EXEC.
  - Never assert both readys.
- EXEC:
  - Drive `as_a`/`as_b`/`as_carry_in` from the latched registers.
  - Drive `as_add_en` = ~op and `as_sub_en` = op; exactly one enable is high.
  - The wait counter starts at 0 on EXEC entry.
  - If `as_out_en` = 1 in a cycle, capture `as_data_out`/`as_carry_out` with err=0, then go to RESP.
  - Else if count == TIMEOUT-1, capture data=0, carry=0, err=1, then go to RESP.
  - Else increment the counter.
- RESP:
  - `rspG_valid` = 1 for exactly one cycle, with registered data/carry/err. The other side's response outputs stay 0.
  - Set `prio` = ~G, then go to IDLE.
- Outside EXEC, `as_a`, `as_b`, `as_carry_in`, `as_add_en`, and `as_sub_en` are all 0.
- No arithmetic in this block; results pass through unmodified.
- `rspN_data`/`carry`/`err` are 0 whenever `rspN_valid` = 0.

## Timing
- Reset values:
  - State IDLE, `prio` = 0, counter 0.
  - All `as_*` outputs are 0.
  - All `rsp*` outputs are 0.
  - `reqN_ready` = 0 whenever `reqN_valid` = 0.
- Accept at edge T (IDLE). EXEC occupies cycle T+1, with enables high from T+1.
- With `as_out_en` immediate, `rspG_valid` is high in cycle T+2. Latency is 2 cycles from accept to response.
- Worst case, EXEC lasts TIMEOUT cycles and `rsp_valid` arrives at T+1+TIMEOUT.
- Throughput is at most one op per 3 cycles; the next accept is possible in the first IDLE cycle after RESP.
- Requesters hold valid and payload until ready. A valid that drops before ready is simply not served.
- Continuous contention alternates strictly: 0, 1, 0, 1…
- Reset asserted in any state (including mid-EXEC or RESP):
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight op is discarded; no response is issued.
  - `prio` returns to 0.

## Test plan
Bench `adder_sub` model: add gives {carry,data} = A+B+cin; sub gives {carry,data} = A+~B+1 (cin=0). `out_en` = add_en|sub_en unless stalled.

- Reset: hold reset 3 cycles with both valids high → both readys 0, all `as_*` and `rsp*` 0, first grant after release goes to req0.
- req0 add a=200, b=100, cin=0 → `as_add_en` high for exactly 1 cycle, `rsp0_valid` pulse 2 cycles after accept with data=44, carry=1, err=0. `rsp1_valid` stays 0.
- req1 sub a=50, b=20 → `as_sub_en` high for 1 cycle, `rsp1` gives data=30, carry=1, err=0. req1 add a=255, b=0, cin=1 → data=0, carry=1.
- Both valid continuously for 6 ops → grants in the order 0, 1, 0, 1, 0, 1. Accepts are 3 cycles apart, and each response matches its own operands.
- Stall model `out_en` = 0, TIMEOUT=4, req0 add → EXEC holds 4 cycles, `rsp0_valid` at accept+5 with err=1, data=0, carry=0. The next request completes normally.
- Assert reset during EXEC of a req1 op → no `rsp1_valid` ever, enables 0 the next cycle, next grant (both valid) goes to req0.
